// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequencing controller for one 8-lane MAC unit with two internal register
// stages. A job (chunk count + precision mode) is accepted through a start
// request in IDLE. Operand chunks are then streamed from an upstream
// valid/ready source into the MAC. The MAC's fixed two-cycle latency is
// tracked with a 2-bit shift register, and the per-chunk dot products are
// summed into a wide signed accumulator. The final sum is presented on a
// valid/ready result port.
//
// Handshake semantics (both the operand port and the result port):
//   A transfer happens on a rising clk edge where valid && ready are both
//   high. The producer holds valid and its data stable until that transfer.
//   ready is allowed to depend on state only. It never depends on the
//   partner's valid, so no combinational loop can form through the
//   handshake.
//
// Ports:
//   clk, reset_n        rising-edge clock, async active-low reset
//   start               job request; acted on only in IDLE
//   cfg_chunks          chunks in the job (unsigned); 0 gives an empty job
//   cfg_mode            00 s*s, 01/10 s*u, 11 treated as 00
//   busy                high whenever the FSM is not in IDLE
//   in_valid/in_ready   operand chunk handshake
//   in_a, in_b          activation / weight chunk, lane 0 at the LSBs
//   mac_a, mac_b        operands to the MAC; zero on non-fire cycles
//   mac_mode            precision mode to the MAC; changes only on accept
//   mac_out             MAC dot-product result (signed, bw_psum bits)
//   res_valid/res_ready result handshake
//   res_data            accumulated signed sum (zero when res_valid is low)
//   dbg_state           current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int cnt_bw  = 8,
    parameter int acc_bw  = bw_psum+cnt_bw
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [cnt_bw-1:0]   cfg_chunks,
    input  logic [1:0]          cfg_mode,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [pr*bw-1:0]    in_a,
    input  logic [pr*bw-1:0]    in_b,
    output logic [pr*bw-1:0]    mac_a,
    output logic [pr*bw-1:0]    mac_b,
    output logic [1:0]          mac_mode,
    input  logic [bw_psum-1:0]  mac_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [acc_bw-1:0]   res_data,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [cnt_bw-1:0]   remaining_q;
    logic [1:0]          mode_q;
    logic [1:0]          v_q;
    logic [acc_bw-1:0]   acc_q;

    logic                accept;
    logic                fire;
    logic [acc_bw-1:0]   mac_out_ext;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (cfg_chunks == '0) ? ST_DONE : ST_FEED;
                end
            end

            ST_FEED: begin
                in_ready = 1'b1;
                if (in_valid && (remaining_q == cnt_bw'(1))) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Once v[0] is clear, the only chunk still in flight sits in
                // v[1]. Its accumulate lands on the same edge that enters
                // DONE, so res_data is already final in the first DONE cycle.
                if (!v_q[0]) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                res_valid = 1'b1;
                // A start in this cycle is deliberately not looked at. It is
                // neither accepted nor remembered.
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fire = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Job registers, pipeline tracking and accumulator
    // -----------------------------------------------------------------------
    assign mac_out_ext = acc_bw'($signed(mac_out));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            mode_q      <= 2'b00;
            v_q         <= 2'b00;
            acc_q       <= '0;
        end else begin
            if (accept) begin
                remaining_q <= cfg_chunks;
                mode_q      <= (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
            end else if (fire) begin
                remaining_q <= remaining_q - cnt_bw'(1);
            end

            // v[0]: product stage holds a real chunk.
            // v[1]: mac_out holds a real chunk's sum.
            // Clearing v on reset discards whatever the un-reset MAC holds.
            v_q <= {v_q[0], fire};

            if (accept) begin
                acc_q <= '0;
            end else if (v_q[1]) begin
                acc_q <= acc_q + mac_out_ext;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Bubbles drive zero operands, so any product the MAC computes for them
    // is zero. Those products are also ignored because v never marks them.
    assign mac_a     = fire ? in_a : '0;
    assign mac_b     = fire ? in_b : '0;
    assign mac_mode  = mode_q;
    assign res_data  = res_valid ? acc_q : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int BW   = 8;
  localparam int PR   = 8;
  localparam int PSUM = 2*BW+4;
  localparam int CNT  = 8;
  localparam int ACC  = PSUM+CNT;
  localparam int DW   = PR*BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic            start = 1'b0;
  logic [CNT-1:0]  cfg_chunks = '0;
  logic [1:0]      cfg_mode = 2'b00;
  logic            busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [1:0]      mac_mode;
  logic [PSUM-1:0] mac_out;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [ACC-1:0]  res_data;
  logic [1:0]      dbg_state;

  mac_seq_ctrl #(.bw(BW), .pr(PR), .bw_psum(PSUM), .cnt_bw(CNT), .acc_bw(ACC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_chunks(cfg_chunks),
    .cfg_mode(cfg_mode), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_mode(mac_mode),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .dbg_state(dbg_state)
  );

  // ---------------- MAC unit model (two register stages, no reset) ----------------
  function automatic int lane_prod(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                   input logic [1:0] m);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = (m == 2'b01 || m == 2'b10) ? int'(b) : int'($signed(b));
    return ai * bi;
  endfunction

  int prod_q [PR];
  int psum_q;
  initial begin
    for (int i = 0; i < PR; i++) prod_q[i] = 1000 + i;
    psum_q = 54321;
  end
  always @(posedge clk) begin
    int s;
    s = 0;
    for (int i = 0; i < PR; i++) begin
      prod_q[i] <= lane_prod(mac_a[i*BW +: BW], mac_b[i*BW +: BW], mac_mode);
      s += prod_q[i];
    end
    psum_q <= s;
  end
  assign mac_out = psum_q[PSUM-1:0];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [ACC-1:0] exp_q[$];
  logic [DW-1:0]  job_a[$];
  logic [DW-1:0]  job_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job-level reference: dot products summed over all chunks, wrapped to ACC bits.
  function automatic logic [ACC-1:0] model_sum(input int n, input logic [1:0] mode);
    logic [1:0] m;
    longint s;
    logic [DW-1:0] ca;
    logic [DW-1:0] cb;
    logic [BW-1:0] la;
    logic [BW-1:0] lb;
    longint av;
    longint bv;
    m = (mode == 2'b11) ? 2'b00 : mode;
    s = 0;
    for (int c = 0; c < n; c++) begin
      ca = job_a[c];
      cb = job_b[c];
      for (int l = 0; l < PR; l++) begin
        la = ca[l*BW +: BW];
        lb = cb[l*BW +: BW];
        av = longint'($signed(la));
        bv = (m == 2'b00) ? longint'($signed(lb)) : longint'(lb);
        s += av * bv;
      end
    end
    return s[ACC-1:0];
  endfunction

  task automatic fill_uniform(input int n, input logic [BW-1:0] a, input logic [BW-1:0] b);
    job_a.delete();
    job_b.delete();
    for (int c = 0; c < n; c++) begin
      job_a.push_back({PR{a}});
      job_b.push_back({PR{b}});
    end
  endtask

  task automatic fill_random(input int n);
    job_a.delete();
    job_b.delete();
    for (int c = 0; c < n; c++) begin
      job_a.push_back({$urandom, $urandom});
      job_b.push_back({$urandom, $urandom});
    end
  endtask

  // ---------------- driver: one complete job ----------------
  // vpct < 0 selects the fixed valid pattern vpat (bit k for attempt k).
  task automatic run_job(input string tag, input int n, input logic [1:0] mode,
                         input int vpct, input logic [31:0] vpat, input int rdly,
                         input logic [1:0] exp_mode, input bit poke_start);
    logic [ACC-1:0] held;
    logic [ACC-1:0] exp_res;
    logic v;
    logic rv0;
    int idx;
    int k;
    int guard;
    int limit;
    int first_fire;
    int last_fire;
    bit fired_any;

    exp_q.push_back(model_sum(n, mode));
    start = 1'b1;
    cfg_chunks = CNT'(n);
    cfg_mode = mode;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_chunks = CNT'($urandom);
    cfg_mode = 2'($urandom);
    @(negedge clk);
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " mac_mode"}, 64'(mac_mode), 64'(exp_mode));
    rv0 = res_valid;

    if (n == 0) begin
      check({tag, " res_valid one edge after start"}, 64'(rv0), 64'd1);
    end else begin
      check({tag, " res_valid low after start"}, 64'(rv0), 64'd0);
      @(posedge clk); #1;
      idx = 0;
      k = 0;
      guard = 0;
      limit = 64 * n + 100;
      fired_any = 1'b0;
      first_fire = 0;
      last_fire = 0;
      while (idx < n && guard < limit) begin
        if (vpct < 0) v = vpat[k % 32];
        else v = ($urandom_range(99) < vpct);
        in_valid = v;
        in_a = job_a[idx];
        in_b = job_b[idx];
        @(negedge clk);
        check({tag, " in_ready in feed"}, 64'(in_ready), 64'd1);
        check({tag, " mac_a"}, 64'(mac_a), v ? 64'(job_a[idx]) : 64'd0);
        check({tag, " mac_b"}, 64'(mac_b), v ? 64'(job_b[idx]) : 64'd0);
        @(posedge clk); #1;
        if (v) begin
          if (!fired_any) first_fire = cyc;
          fired_any = 1'b1;
          last_fire = cyc;
          idx++;
        end
        k++;
        guard++;
      end
      if (idx < n) check({tag, " feed timeout"}, 64'(idx), 64'(n));
      in_valid = 1'b0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      guard = 0;
      @(negedge clk);
      check({tag, " in_ready low in drain"}, 64'(in_ready), 64'd0);
      check({tag, " mac_a zero in drain"}, 64'(mac_a), 64'd0);
      while (!res_valid && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check({tag, " res_valid seen"}, 64'(res_valid), 64'd1);
      check({tag, " edges last fire to res_valid"}, 64'(cyc - last_fire), 64'd2);
      if (vpct >= 100)
        check({tag, " edges first fire to res_valid"}, 64'(cyc - first_fire + 1), 64'(n + 2));
    end

    exp_res = exp_q.pop_front();
    check({tag, " res_data"}, 64'(res_data), 64'(exp_res));
    held = res_data;
    for (int i = 0; i < rdly; i++) begin
      if (poke_start) begin
        start = 1'b1;
        cfg_chunks = CNT'(5);
      end
      @(negedge clk);
      check({tag, " res_valid held"}, 64'(res_valid), 64'd1);
      check({tag, " res_data held"}, 64'(res_data), 64'(held));
      check({tag, " busy held"}, 64'(busy), 64'd1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check({tag, " busy after handshake"}, 64'(busy), 64'd0);
    check({tag, " res_valid after handshake"}, 64'(res_valid), 64'd0);
    check({tag, " res_data after handshake"}, 64'(res_data), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int             n;
    logic [1:0]     mode;
    logic [BW-1:0]  a;
    logic [BW-1:0]  b;
    logic [ACC-1:0] exp_res;
    logic [1:0]     exp_mode;
  } vec_t;

  vec_t vecs [7];
  logic [ACC-1:0] neg2040;
  logic [ACC-1:0] big;

  initial begin
    neg2040 = ACC'(-2040);
    big = ACC'(33423360);
    vecs[0] = '{n: 4,   mode: 2'b00, a: 8'h01, b: 8'h01, exp_res: ACC'(32), exp_mode: 2'b00};
    vecs[1] = '{n: 1,   mode: 2'b00, a: 8'hFF, b: 8'hFF, exp_res: ACC'(8),  exp_mode: 2'b00};
    vecs[2] = '{n: 1,   mode: 2'b01, a: 8'hFF, b: 8'hFF, exp_res: neg2040,  exp_mode: 2'b01};
    vecs[3] = '{n: 1,   mode: 2'b10, a: 8'hFF, b: 8'hFF, exp_res: neg2040,  exp_mode: 2'b10};
    vecs[4] = '{n: 1,   mode: 2'b11, a: 8'hFF, b: 8'hFF, exp_res: ACC'(8),  exp_mode: 2'b00};
    vecs[5] = '{n: 2,   mode: 2'b00, a: 8'h02, b: 8'h02, exp_res: ACC'(64), exp_mode: 2'b00};
    vecs[6] = '{n: 255, mode: 2'b00, a: 8'h80, b: 8'h80, exp_res: big,      exp_mode: 2'b00};

    // ---- reset state ----
    #3;
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_data", 64'(res_data), 64'd0);
    check("reset mac_a", 64'(mac_a), 64'd0);
    check("reset mac_b", 64'(mac_b), 64'd0);
    check("reset mac_mode", 64'(mac_mode), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- table-driven jobs ----
    for (int i = 0; i < 7; i++) begin
      fill_uniform(vecs[i].n, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d table vs model", i), 64'(model_sum(vecs[i].n, vecs[i].mode)),
            64'(vecs[i].exp_res));
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].mode, 100, 32'h0, 0,
              vecs[i].exp_mode, 1'b0);
    end

    // ---- bubbles: valid pattern 1,0,1,0,1 ----
    job_a.delete();
    job_b.delete();
    for (int c = 0; c < 3; c++) begin
      job_a.push_back(DW'(3));
      job_b.push_back(DW'(5));
    end
    check("bubble model", 64'(model_sum(3, 2'b00)), 64'd45);
    run_job("bubble", 3, 2'b00, -1, 32'h5555_5555, 0, 2'b00, 1'b0);

    // ---- zero-length job, then backpressure with start poked during DONE ----
    job_a.delete();
    job_b.delete();
    run_job("zero_len", 0, 2'b01, 100, 32'h0, 2, 2'b01, 1'b0);
    fill_random(3);
    run_job("backpressure", 3, 2'b00, 100, 32'h0, 5, 2'b00, 1'b1);

    // ---- mid-job reset during DRAIN ----
    fill_random(8);
    start = 1'b1;
    cfg_chunks = CNT'(8);
    cfg_mode = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_a = job_a[c];
      in_b = job_b[c];
      @(posedge clk); #1;
    end
    check("midreset busy before", 64'(busy), 64'd1);
    check("midreset in_ready before", 64'(in_ready), 64'd0);
    in_a = {$urandom, $urandom};
    reset_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd0);
    check("midreset res_valid", 64'(res_valid), 64'd0);
    check("midreset res_data", 64'(res_data), 64'd0);
    check("midreset mac_a", 64'(mac_a), 64'd0);
    check("midreset mac_mode", 64'(mac_mode), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    fill_uniform(2, 8'h02, 8'h02);
    run_job("after_reset", 2, 2'b00, 100, 32'h0, 0, 2'b00, 1'b0);

    // ---- randomized jobs ----
    for (int j = 0; j < 15; j++) begin
      int n;
      logic [1:0] m;
      n = $urandom_range(1, 12);
      m = 2'($urandom_range(0, 3));
      fill_random(n);
      run_job($sformatf("rand%0d", j), n, m, $urandom_range(40, 100), 32'h0,
              $urandom_range(0, 4), (m == 2'b11) ? 2'b00 : m, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
